uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum WAIT-state cycles before abort.
REQ-003 SHALL have one clock and synchronous active-high reset: port baud, input, 1 bit, clock (rising edge).
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port req, input, NREQ bits, per-requester level request to send one byte.
REQ-006 SHALL have port req_data, input, 8*NREQ bits, byte for requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_en, input, NREQ bits, per-requester enable mask; a 0 bit ignores that request.
REQ-008 SHALL have port gnt, output, NREQ bits, one-hot one-cycle pulse: byte accepted.
REQ-009 SHALL have port done, output, NREQ bits, one-hot one-cycle pulse: granted byte's frame completed.
REQ-010 SHALL have port tx_data, output, 8 bits, byte to the transmitter data input.
REQ-011 SHALL have port tx_en, output, 1 bit, transmitter start request.
REQ-012 SHALL have port tx_done, input, 1 bit, transmitter data_st completion flag.
REQ-013 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-014 SHALL have port err, output, 1 bit, one-cycle pulse on timeout abort.

Function
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT; every transition on a rising edge of baud.
REQ-016 IDLE: if (req & req_en) is nonzero, SHALL pick winner w round-robin, latch req_data[w] into tx_data, pulse gnt[w], store sel=w, go to LAUNCH; otherwise stay IDLE.
REQ-017 Round-robin SHALL search ptr+1, ptr+2, ... modulo NREQ; ptr is the last requester to complete or abort.
REQ-018 LAUNCH SHALL last exactly one cycle with tx_en=1, then go to WAIT; tx_en SHALL be 0 in all other states.
REQ-019 tx_data SHALL hold stable from grant until the FSM returns to IDLE.
REQ-020 WAIT SHALL count cycles from 0; tx_done=1 sampled SHALL pulse done[sel], set ptr=sel, clear the counter, and go to IDLE.
REQ-021 When the WAIT counter reaches TIMEOUT without tx_done, the block SHALL pulse err, set ptr=sel, assert no done, and go to IDLE.
REQ-022 tx_done sampled in IDLE or LAUNCH SHALL be ignored.
REQ-023 A requester keeping req high after gnt SHALL be treated as a new request at the next IDLE arbitration, behind other active requesters.
REQ-024 Changes to req, req_data or req_en after grant SHALL not affect the byte in flight.
REQ-025 Minimum IDLE dwell between frames SHALL be one cycle, so the transmitter sees tx_en=0 in its idle cycle after stop.
REQ-026 Nominal latency: tx_en high at cycle G (grant edge), tx_done sampled at G+12, done pulse visible the following cycle.

Reset
REQ-027 reset=1 on a rising edge SHALL force state=IDLE, gnt=0, done=0, err=0, tx_en=0, busy=0, tx_data=8'h00, counter=0, ptr=NREQ-1, so requester 0 has first priority.
REQ-028 Reset mid-frame SHALL abandon the frame without done or err; reset SHALL take priority over all other inputs.

Verification
REQ-029 Single request: req=4'b0100, req_data[23:16]=8'hA5, paired transmitter -> gnt=4'b0100 one cycle, tx_en one cycle, serial line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), done=4'b0100.
REQ-030 All four requesting continuously after reset -> grant order 0,1,2,3,0; each done precedes the next gnt; no overlapping tx_en.
REQ-031 tx_done tied 0 -> err pulses after TIMEOUT WAIT cycles, no done, busy falls, next arbitration starts after ptr=sel.
REQ-032 req=4'b1111, req_en=4'b0101 -> only requesters 0 and 2 granted, alternating.
REQ-033 reset asserted for one cycle during WAIT -> all outputs at reset values next cycle, no done or err, requester 0 wins the next arbitration.
REQ-034 req_data changed one cycle after gnt -> transmitted byte equals the byte latched at grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one UART transmitter,
// one byte per grant, with a WAIT-state timeout that aborts a stuck frame.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              baud,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_en,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_done,
    output logic              busy,
    output logic              err
);

    // state  | meaning
    // IDLE   | arbitrating; a winner is latched and granted on the next edge
    // LAUNCH | single cycle with tx_en high to start the transmitter
    // WAIT   | counting cycles until tx_done, or abort at TIMEOUT cycles
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] active;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand_idx;
    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] sel_onehot;
    logic [7:0]      win_byte;
    int              cand;

    assign active = req & req_en;
    assign busy   = (state != IDLE);

    // Search ptr+1, ptr+2, ... wrapping at NREQ; the last-served requester comes last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ)
                cand = cand - NREQ;
            cand_idx = PW'(cand);
            if (!win_valid && active[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        sel_onehot = '0;
        win_byte   = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            win_onehot[i] = (PW'(i) == win_idx);
            sel_onehot[i] = (PW'(i) == sel);
            if (PW'(i) == win_idx)
                win_byte = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge baud) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
            cnt     <= '0;
            ptr     <= PTR_INIT;
            sel     <= '0;
        end else begin
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        tx_data <= win_byte;
                        gnt     <= win_onehot;
                        sel     <= win_idx;
                        tx_en   <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        done  <= sel_onehot;
                        ptr   <= sel;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        ptr   <= sel;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a paired UART transmitter model that
// serialises each launched byte and raises tx_done after the stop bit.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic              baud = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_en;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_done;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .baud     (baud),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_en   (req_en),
        .gnt      (gnt),
        .done     (done),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_done  (tx_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 baud = ~baud;

    // Transmitter model: runs on the falling edge so it never races the DUT.
    logic       xmit_dead = 1'b0;
    logic       tx_active = 1'b0;
    logic       line      = 1'b1;
    logic [9:0] shreg     = '1;
    logic [9:0] frame_cap = '0;
    int         bitn      = 0;
    int         overlap   = 0;

    initial tx_done = 1'b0;

    always @(negedge baud) begin
        if (tx_en && tx_active)
            overlap++;
        if (tx_active) begin
            if (bitn < 10) begin
                line            = shreg[bitn];
                frame_cap[bitn] = line;
                bitn++;
            end else if (bitn == 10) begin
                line    = 1'b1;
                tx_done = 1'b1;
                bitn++;
            end else begin
                tx_done   = 1'b0;
                tx_active = 1'b0;
            end
        end else if (tx_en && !xmit_dead) begin
            shreg     = {1'b1, tx_data, 1'b0};
            frame_cap = '0;
            tx_active = 1'b1;
            bitn      = 0;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic [7:0] base;
        logic [3:0] exp_gnt;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < NREQ; i++)
            req_data[8*i +: 8] = base + 8'(i);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},     gnt,     '0);
        check({tag, "_done"},    done,    '0);
        check({tag, "_err"},     err,     0);
        check({tag, "_tx_en"},   tx_en,   0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
    endtask

    task automatic run_txn(input vec_t v);
        int cyc;
        req_en = v.en;
        set_data(v.base);
        req = v.req;
        cyc = 0;
        do begin
            @(negedge baud);
            cyc++;
        end while (gnt == '0 && cyc < 40);
        check("gnt", gnt, v.exp_gnt);
        check("gnt_lat", cyc, 1);
        check("tx_en_launch", tx_en, 1);
        check("tx_data_grant", tx_data, v.exp_byte);
        check("busy_launch", busy, 1);
        req = '0;
        @(negedge baud);
        cyc = 1;
        check("tx_en_one_cycle", tx_en, 0);
        req_data = '1;
        req_en   = '0;
        while (done == '0 && !err && cyc < 40) begin
            @(negedge baud);
            cyc++;
        end
        check("done", done, v.exp_gnt);
        check("no_err", err, 0);
        check("done_lat", cyc, 12);
        check("tx_data_hold", tx_data, v.exp_byte);
        check("frame", frame_cap, {1'b1, v.exp_byte, 1'b0});
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (done == '0 && cyc < budget) begin
            @(negedge baud);
            cyc++;
        end
        check("drain_done_seen", (done != '0), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        cyc;
        int        ng;
        int        ndone;
        logic      saw;
        logic [3:0] order [5];

        vecs[0] = '{4'b0100, 4'b1111, 8'hA3, 4'b0100, 8'hA5};
        vecs[1] = '{4'b1111, 4'b1111, 8'h10, 4'b1000, 8'h13};
        vecs[2] = '{4'b1111, 4'b0101, 8'h20, 4'b0001, 8'h20};
        vecs[3] = '{4'b1111, 4'b0101, 8'h30, 4'b0100, 8'h32};
        vecs[4] = '{4'b1111, 4'b0101, 8'h40, 4'b0001, 8'h40};
        vecs[5] = '{4'b0011, 4'b1111, 8'h5C, 4'b0010, 8'h5D};
        vecs[6] = '{4'b0011, 4'b1111, 8'h6E, 4'b0001, 8'h6E};
        vecs[7] = '{4'b1001, 4'b1111, 8'h7F, 4'b1000, 8'h82};

        reset    = 1'b1;
        req      = '0;
        req_en   = '1;
        req_data = '0;
        repeat (2) @(negedge baud);
        reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i]);

        // All four requesting continuously from reset: 0,1,2,3,0.
        reset = 1'b1;
        @(negedge baud);
        reset = 1'b0;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        set_data(8'h90);
        req_en = 4'b1111;
        req    = 4'b1111;
        ng     = 0;
        ndone  = 0;
        cyc    = 0;
        while (ng < 5 && cyc < 200) begin
            @(negedge baud);
            cyc++;
            if (done != '0)
                ndone++;
            if (gnt != '0) begin
                check("rr_order", gnt, order[ng]);
                check("rr_done_before_gnt", ndone, ng);
                ng++;
            end
        end
        check("rr_grant_count", ng, 5);
        req = '0;
        wait_done(20);
        check("rr_no_overlap", overlap, 0);

        // Dead transmitter: abort after TIMEOUT WAIT cycles, ptr moves to 1.
        xmit_dead = 1'b1;
        set_data(8'hB0);
        req_en = 4'b1111;
        req    = 4'b0010;
        cyc    = 0;
        do begin
            @(negedge baud);
            cyc++;
        end while (gnt == '0 && cyc < 40);
        check("to_gnt", gnt, 4'b0010);
        req = '0;
        saw = 1'b0;
        cyc = 0;
        while (!err && cyc < 60) begin
            @(negedge baud);
            cyc++;
            if (done != '0)
                saw = 1'b1;
        end
        check("to_err", err, 1);
        check("to_err_lat", cyc, TIMEOUT + 1);
        check("to_no_done", saw, 0);
        check("to_busy_low", busy, 0);
        @(negedge baud);
        check("to_err_one_cycle", err, 0);
        xmit_dead = 1'b0;
        run_txn('{4'b1111, 4'b1111, 8'hC0, 4'b0100, 8'hC2});

        // Reset in the middle of WAIT abandons the frame silently.
        set_data(8'hD0);
        req_en = 4'b1111;
        req    = 4'b1000;
        cyc    = 0;
        do begin
            @(negedge baud);
            cyc++;
        end while (gnt == '0 && cyc < 40);
        check("rw_gnt", gnt, 4'b1000);
        req = '0;
        repeat (4) @(negedge baud);
        check("rw_busy_in_wait", busy, 1);
        reset = 1'b1;
        @(negedge baud);
        reset = 1'b0;
        check_reset_values("rw");
        saw = 1'b0;
        repeat (16) begin
            @(negedge baud);
            if (done != '0 || err || busy)
                saw = 1'b1;
        end
        check("rw_quiet_after_reset", saw, 0);
        run_txn('{4'b1111, 4'b1111, 8'hE0, 4'b0001, 8'hE0});
        check("no_tx_en_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
